// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch/countdown display datapath.
// Conditions the start/clear keys and the mode/preset switches, generates the
// one-second tick, sequences IDLE/LOAD/RUN/PAUSE/DONE and drives a timed alarm.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   key_start   start/stop key, async level
//   key_clear   clear key, async level
//   sw_mode     0 = stopwatch (count up), 1 = timer (count down)
//   sw_preset   timer preset: 00 = 15 s, 01 = 30 s, 1x = 45 s
//   done_time   datapath countdown reached 0:00
//   dp_reset    synchronous load/reset strobe to the datapath (high in LOAD)
//   one_second  one-cycle tick while running
//   start_clk   datapath count enable
//   timer       registered mode
//   fifteen/thirty/fortyfive  registered one-hot preset (all 0 in stopwatch mode)
//   alarm       countdown-expired indicator
//   state       IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       sw_mode,
  input  logic [1:0] sw_preset,
  input  logic       done_time,
  output logic       dp_reset,
  output logic       one_second,
  output logic       start_clk,
  output logic       timer,
  output logic       fifteen,
  output logic       thirty,
  output logic       fortyfive,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int unsigned DIV_W = $clog2(CLK_HZ);
  localparam int unsigned ALM_W = $clog2(ALARM_SECS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SECS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       start_sync, clear_sync;
  logic             start_last, clear_last;
  logic             start_p_c, clear_p_c;
  logic [2:0]       cfg_sync1, cfg_sync2, cfg_q;
  logic             cfg_chg_q, cfg_diff_c;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [ALM_W-1:0] alm_cnt;

  // Key synchronizers and rising-edge detectors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync <= '0;
      clear_sync <= '0;
      start_last <= 1'b0;
      clear_last <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], key_start};
      clear_sync <= {clear_sync[0], key_clear};
      start_last <= start_sync[1];
      clear_last <= clear_sync[1];
    end
  end

  assign start_p_c = start_sync[1] & ~start_last;
  assign clear_p_c = clear_sync[1] & ~clear_last;

  // Switch synchronizer; new configuration is only accepted while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_sync1 <= '0;
      cfg_sync2 <= '0;
    end else begin
      cfg_sync1 <= {sw_mode, sw_preset};
      cfg_sync2 <= cfg_sync1;
    end
  end

  assign cfg_diff_c = (state_q == ST_IDLE) && (cfg_sync2 != cfg_q);

  // Tick fires on the wrap of the divider while it is counting
  assign tick_c = ((state_q == ST_RUN) || (state_q == ST_DONE)) && (div_cnt == DIV_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: state_d = ST_IDLE;
      ST_IDLE: begin
        // A pending or freshly detected switch change swallows a start pulse
        if (clear_p_c || cfg_chg_q)          state_d = ST_LOAD;
        else if (start_p_c && !cfg_diff_c)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_p_c)                       state_d = ST_LOAD;
        else if (start_p_c)                  state_d = ST_PAUSE;
        else if (timer && done_time)         state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (clear_p_c)                       state_d = ST_LOAD;
        else if (start_p_c)                  state_d = ST_RUN;
      end
      ST_DONE: begin
        if (clear_p_c || start_p_c)          state_d = ST_LOAD;
        else if (tick_c && (alm_cnt == ALM_LAST)) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  assign state = 3'(state_q);

  // Tick divider: counts in RUN/DONE, holds in PAUSE, restarts on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else begin
      case (state_q)
        ST_RUN, ST_DONE: begin
          if (tick_c || (state_q == ST_RUN && state_d == ST_DONE)) div_cnt <= '0;
          else                                                     div_cnt <= div_cnt + DIV_W'(1);
        end
        ST_PAUSE: div_cnt <= div_cnt;
        default:  div_cnt <= '0;
      endcase
    end
  end

  // Alarm duration counter, counts ticks spent in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  alm_cnt <= '0;
    else if (state_q != ST_DONE) alm_cnt <= '0;
    else if (tick_c)             alm_cnt <= alm_cnt + ALM_W'(1);
  end

  // Registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_reset   <= 1'b1;
      start_clk  <= 1'b0;
      alarm      <= 1'b0;
      one_second <= 1'b0;
    end else begin
      dp_reset   <= (state_d == ST_LOAD);
      start_clk  <= (state_d == ST_RUN);
      alarm      <= (state_d == ST_DONE);
      one_second <= tick_c && (state_q == ST_RUN);
    end
  end

  // Registered mode/preset; a change flags a reload on the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q     <= '0;
      cfg_chg_q <= 1'b0;
      timer     <= 1'b0;
      fifteen   <= 1'b0;
      thirty    <= 1'b0;
      fortyfive <= 1'b0;
    end else begin
      cfg_chg_q <= cfg_diff_c;
      if (cfg_diff_c) begin
        cfg_q     <= cfg_sync2;
        timer     <= cfg_sync2[2];
        fifteen   <= cfg_sync2[2] && (cfg_sync2[1:0] == 2'b00);
        thirty    <= cfg_sync2[2] && (cfg_sync2[1:0] == 2'b01);
        fortyfive <= cfg_sync2[2] && cfg_sync2[1];
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with CLK_HZ=10, ALARM_SECS=2.
// A behavioural model predicts every output after every clock edge; directed
// steps add explicit latency and boundary checks, then a random phase follows.
module tb_stopwatch_ctrl;

  localparam int HZ = 10;
  localparam int AS = 2;

  logic       clk, reset, key_start, key_clear, sw_mode, done_time;
  logic [1:0] sw_preset;
  logic       dp_reset, one_second, start_clk, timer, fifteen, thirty, fortyfive, alarm;
  logic [2:0] state;

  stopwatch_ctrl #(.CLK_HZ(HZ), .ALARM_SECS(AS)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_clear(key_clear),
    .sw_mode(sw_mode), .sw_preset(sw_preset), .done_time(done_time),
    .dp_reset(dp_reset), .one_second(one_second), .start_clk(start_clk),
    .timer(timer), .fifteen(fifteen), .thirty(thirty), .fortyfive(fortyfive),
    .alarm(alarm), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] dut_vec;
  assign dut_vec = {state, dp_reset, one_second, start_clk, timer, fifteen, thirty, fortyfive, alarm};

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model state (0=IDLE 1=LOAD 2=RUN 3=PAUSE 4=DONE)
  int          m_state;
  logic [2:0]  m_cfg;
  bit          m_pend, m_tick;
  int          run_acc, done_acc;
  bit [3:0]    ks_h, kc_h;
  logic [2:0]  cfg_h0, cfg_h1, cfg_h2;
  logic [10:0] exp_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, expv);
  endtask

  task automatic set_exp(input int nxt);
    exp_vec = {3'(nxt), nxt == 1, m_tick, nxt == 2, m_cfg[2],
               m_cfg[2] && (m_cfg[1:0] == 2'b00), m_cfg[2] && (m_cfg[1:0] == 2'b01),
               m_cfg[2] && m_cfg[1], nxt == 4};
  endtask

  task automatic model_reset();
    m_state = 1; m_cfg = '0; m_pend = 0; m_tick = 0;
    run_acc = 0; done_acc = 0;
    ks_h = '0; kc_h = '0; cfg_h0 = '0; cfg_h1 = '0; cfg_h2 = '0;
    set_exp(1);
  endtask

  // One clock edge of the reference: keys act two edges after being sampled
  // (if they were low the edge before), switches are seen two edges later.
  task automatic model_edge();
    int nxt, s;
    bit sp, cp, chg, alarm_end;
    ks_h = {ks_h[2:0], key_start};
    kc_h = {kc_h[2:0], key_clear};
    cfg_h2 = cfg_h1; cfg_h1 = cfg_h0; cfg_h0 = {sw_mode, sw_preset};
    sp = ks_h[2] && !ks_h[3];
    cp = kc_h[2] && !kc_h[3];
    s = m_state;
    chg = (s == 0) && (cfg_h2 != m_cfg);
    m_tick = (s == 2) && (((run_acc + 1) % HZ) == 0);
    alarm_end = (s == 4) && ((done_acc + 1) == AS * HZ);
    nxt = s;
    case (s)
      1: nxt = 0;
      0: if (cp || m_pend) nxt = 1; else if (sp && !chg) nxt = 2;
      2: if (cp) nxt = 1; else if (sp) nxt = 3; else if (m_cfg[2] && done_time) nxt = 4;
      3: if (cp) nxt = 1; else if (sp) nxt = 2;
      4: if (cp || sp || alarm_end) nxt = 1;
      default: nxt = 1;
    endcase
    if (s == 2) run_acc++;
    else if (s == 0 || s == 1) run_acc = 0;
    if (s == 4) done_acc++;
    if (nxt == 4 && s != 4) done_acc = 0;
    if (chg) m_cfg = cfg_h2;
    m_pend = chg;
    m_state = nxt;
    set_exp(nxt);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    #1;
    cyc++;
    check("cycle", 32'(dut_vec), 32'(exp_vec));
  endtask

  task automatic press(input bit s, input bit c);
    key_start = s; key_clear = c;
    step(); step(); step();
    key_start = 1'b0; key_clear = 1'b0;
  endtask

  initial begin
    int ticks[$];
    int n;
    int r;
    reset = 1'b0; key_start = 1'b0; key_clear = 1'b0;
    sw_mode = 1'b0; sw_preset = 2'b00; done_time = 1'b0;
    model_reset();

    // Reset values
    step(); step(); step();
    check("rst_state", 32'(state), 32'd1);
    check("rst_dp_reset", 32'(dp_reset), 32'd1);
    check("rst_outs", 32'({one_second, start_clk, timer, fifteen, thirty, fortyfive, alarm}), 32'd0);
    reset = 1'b1;
    step();
    check("post_rst_idle", 32'({state, dp_reset}), 32'd0);

    // Stopwatch run: ticks at entry+10, +20, +30
    press(1'b1, 1'b0);
    check("sw_run", 32'({state, start_clk}), 32'b101);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (one_second) ticks.push_back(k);
    end
    check("tick_count", 32'(ticks.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("tick_pos", (i < ticks.size()) ? 32'(ticks[i]) : 32'hffff, 32'((i + 1) * HZ));

    // Pause 4 RUN cycles after a tick, stay paused, resume: tick 6 RUN cycles later
    step();
    press(1'b1, 1'b0);
    check("pause", 32'({state, start_clk}), 32'b110);
    for (int k = 0; k < 22; k++) step();
    press(1'b1, 1'b0);
    check("resume", 32'(state), 32'd2);
    n = 0;
    do begin step(); n++; end while (one_second !== 1'b1 && n < 20);
    check("resume_tick", 32'(n), 32'd6);

    // Back to IDLE, then select timer mode with the 30 s preset
    press(1'b0, 1'b1);
    check("clear_load", 32'({state, dp_reset}), 32'b0011);
    step();
    sw_mode = 1'b1; sw_preset = 2'b01;
    step(); step(); step();
    check("preset30", 32'({timer, fifteen, thirty, fortyfive}), 32'b1010);
    step();
    check("preset_dp", 32'({state, dp_reset}), 32'b0011);
    step();
    press(1'b1, 1'b0);
    check("timer_run", 32'(state), 32'd2);
    for (int k = 0; k < 5; k++) step();
    done_time = 1'b1;
    step();
    done_time = 1'b0;
    check("done", 32'({state, alarm, start_clk}), 32'b10010);
    n = 0;
    do begin step(); n++; end while (alarm === 1'b1 && n < 40);
    check("alarm_len", 32'(n), 32'(AS * HZ));
    check("alarm_load", 32'({state, dp_reset}), 32'b0011);
    step();
    check("alarm_idle", 32'({state, alarm}), 32'd0);

    // Simultaneous keys in RUN: clear wins
    press(1'b1, 1'b0);
    step(); step(); step();
    press(1'b1, 1'b1);
    check("both_keys", 32'(state), 32'd1);
    step();

    // Preset change while running takes effect only after returning to IDLE
    press(1'b1, 1'b0);
    sw_preset = 2'b10;
    for (int k = 0; k < 6; k++) step();
    check("preset_hold", 32'({fifteen, thirty, fortyfive}), 32'b010);
    press(1'b0, 1'b1);
    n = 0;
    do begin step(); n++; end while (fortyfive !== 1'b1 && n < 10);
    check("new_preset_lat", 32'(n), 32'd2);
    step();
    check("new_preset_dp", 32'({state, dp_reset}), 32'b0011);

    // Randomised phase
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom % 100);
      if (r < 6) key_start = ~key_start;
      else if (r < 8) key_clear = ~key_clear;
      done_time = (($urandom % 8) == 0);
      if (($urandom % 60) == 0) sw_mode = 1'($urandom);
      if (($urandom % 40) == 0) sw_preset = 2'($urandom);
      step();
    end
    key_start = 1'b0; key_clear = 1'b0; done_time = 1'b0;

    // Reset asserted mid-RUN forces reset values immediately
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) step();
    press(1'b1, 1'b0);
    check("rst_run", 32'(state), 32'd2);
    step(); step(); step(); step();
    reset = 1'b0;
    #1;
    check("async_rst", 32'({state, dp_reset, start_clk, alarm, one_second}), 32'b0011000);
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch/countdown display datapath. It turns the board's start/stop and clear keys and the mode and preset switches into the datapath's `one_second`, `start_clk`, `timer`, `fifteen`/`thirty`/`fortyfive` and synchronous load-reset strobes. It also watches the datapath's `done_time` and drives a timed alarm. It sits between the board I/O and the seven-segment display datapath.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per `one_second` tick. Must be ≥ 2.
- `ALARM_SECS`, default 5: ticks the alarm stays high before auto-clear. Must be ≥ 1.

- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset. Asserted at 0.
- `key_start` in 1: start/stop key, active-high level, asynchronous to `clk`.
- `key_clear` in 1: clear key, active-high level, asynchronous to `clk`.
- `sw_mode` in 1: 0 selects stopwatch (count up), 1 selects timer (count down).
- `sw_preset` in 2: timer preset. 00 = 15 s, 01 = 30 s, 10 and 11 = 45 s.
- `done_time` in 1: datapath countdown reached 0:00.
- `dp_reset` out 1: synchronous load/reset strobe to the datapath, active-high.
- `one_second` out 1: one-cycle tick pulse.
- `start_clk` out 1: datapath count enable.
- `timer` out 1: registered mode sent to the datapath.
- `fifteen`, `thirty`, `fortyfive` out 1 each: one-hot preset. All three are 0 in stopwatch mode.
- `alarm` out 1: countdown-expired indicator.
- `state` out 3: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- **Key conditioning:** each key passes through a 2-flop synchronizer and then a rising-edge detector. This produces one-cycle internal pulses `start_p` and `clear_p`. `sw_mode` and `sw_preset` are also 2-flop synchronized.
- **Registered outputs:** `timer` and the preset one-hot update only while in IDLE, one cycle after the synchronized switch value changes. A change also forces IDLE→LOAD, so the datapath reloads with the new configuration.
- **Tick divider:** counts 0..CLK_HZ-1.
  - Advances in RUN and DONE.
  - Holds its value in PAUSE.
  - Cleared to 0 in IDLE and LOAD.
  - Internal tick fires when the count wraps.
  - `one_second` = tick AND (state == RUN).

**FSM states and outputs:**
- **LOAD:** `dp_reset`=1 for exactly one cycle, then go to IDLE. Clears the alarm counter.
- **IDLE:** `start_clk`=0.
  - `clear_p` or a switch change → LOAD.
  - `start_p` → RUN.
- **RUN:** `start_clk`=1.
  - `clear_p` → LOAD.
  - `start_p` → PAUSE.
  - `timer` && `done_time` → DONE.
- **PAUSE:** `start_clk`=0.
  - `clear_p` → LOAD.
  - `start_p` → RUN.
- **DONE:** `start_clk`=0, `alarm`=1.
  - Each tick increments the alarm counter (width `$clog2(ALARM_SECS+1)`).
  - When the counter reaches ALARM_SECS, or on `clear_p` or `start_p` → LOAD.

**Priority when events coincide:** `clear_p` > `start_p` > `done_time`. A switch change in IDLE coincident with `start_p` goes to LOAD, and the start pulse is dropped.

**Other rules:**
- `done_time` is ignored outside RUN and whenever `timer`=0.
- Unused state encodings (5..7) → LOAD on the next cycle.

## Timing
**Reset values** (while `reset`=0):
- `state`=LOAD.
- `dp_reset`=1.
- `one_second`=0, `start_clk`=0, `alarm`=0.
- `timer`=0, `fifteen`=`thirty`=`fortyfive`=0.
- Divider, alarm counter and synchronizers = 0.

**Reset release and LOAD:**
- After `reset` is released: one LOAD cycle with `dp_reset`=1, then IDLE.
- Reset asserted mid-RUN or mid-DONE immediately forces the reset values, with no glitch on `start_clk`.

**Latencies:**
- Key edge to state change: 3 cycles (2 synchronizer cycles plus 1 edge-detect cycle). The new state is visible on the following edge.
- Switch change to `timer`/preset outputs: 3 cycles. `dp_reset` follows one cycle after that.

**Tick timing:**
- First `one_second` occurs CLK_HZ cycles after entering RUN from IDLE.
- Pause/resume preserves the partial count: total RUN cycles between ticks = CLK_HZ.

**Other outputs:**
- All outputs are registered.
- `dp_reset` is high in exactly the cycles where `state`==LOAD.
- `alarm` lasts ALARM_SECS×CLK_HZ cycles if not cleared.

## Test plan
Bench uses CLK_HZ=10, ALARM_SECS=2.
1. **Reset.** Release `reset`. Expect one cycle of `dp_reset`=1 and `state`=1, then `state`=0. All other outputs 0.
2. **Stopwatch run.** Set `sw_mode`=0 and pulse `key_start`. Expect `state`=2 and `start_clk`=1 three cycles later. Expect `one_second` pulses at entry+10, +20, +30.
3. **Pause/resume.** In RUN, pause 4 cycles after a tick, hold PAUSE 25 cycles, then resume. Expect the next `one_second` exactly 6 RUN cycles after resume.
4. **Timer preset and done.**
   - Set `sw_mode`=1, `sw_preset`=01. Expect `thirty`=1, then a `dp_reset` pulse.
   - Start, then assert `done_time`. Expect DONE, `alarm`=1 and `start_clk`=0.
   - After 20 cycles expect LOAD then IDLE, with `alarm`=0.
5. **Simultaneous keys.** Pulse `key_start` and `key_clear` together in RUN. Expect LOAD, not PAUSE.
6. **Switch change while running.** In RUN change `sw_preset`. Expect preset outputs unchanged until IDLE. Clear, then expect the new one-hot plus `dp_reset`.
